// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared FSM states, GRB byte-slot indices, timing defaults and byte-packing helper
package ws2812_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, SEND, LATCH, GAP} state_t;
  localparam logic [1:0] SLOT_G = 2'd0;
  localparam logic [1:0] SLOT_R = 2'd1;
  localparam logic [1:0] SLOT_B = 2'd2;
  localparam int DEF_RESET_CYCLES = 14000;
  localparam int DEF_DELAY_UNIT = 50000;
  function automatic logic [23:0] put_byte(input logic [23:0] w, input logic [1:0] slot, input logic [7:0] b);
    return slot == SLOT_G ? {b, w[15:0]} : slot == SLOT_R ? {w[23:16], b, w[7:0]} : {w[23:8], b};
  endfunction
endpackage

// File: rtl/ws2812_delay_timer.sv
// ws2812_delay_timer: loadable down-counter, optionally prescaled by UNIT; o_done marks the last counted cycle
module ws2812_delay_timer #(
  parameter int UNIT = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_load,
  input  logic        i_prescale,
  input  logic [15:0] i_count,
  output logic        o_done
);
  localparam int PW = $clog2(UNIT + 1);
  logic [15:0]   r_cnt;
  logic [PW-1:0] r_pre;
  logic          r_scale;
  logic [PW-1:0] w_reload;
  assign w_reload = r_scale ? PW'(UNIT - 1) : '0;
  assign o_done = (r_cnt == 16'd1) && (r_pre == '0);
  // prescaler ticks down first, then one count is consumed per full unit
  always_ff @(posedge clk)
    if (reset) begin
      r_cnt <= '0;
      r_pre <= '0;
      r_scale <= 1'b0;
    end else if (i_load) begin
      r_cnt <= i_count;
      r_pre <= i_prescale ? PW'(UNIT - 1) : '0;
      r_scale <= i_prescale;
    end else if (r_cnt != '0) begin
      if (r_pre == '0) begin
        r_cnt <= r_cnt - 16'd1;
        r_pre <= w_reload;
      end else r_pre <= r_pre - PW'(1);
    end
endmodule

// File: rtl/ws2812_frame_sched.sv
// ws2812_frame_sched: pops GRB bytes, hands packed words to the serializer, then runs latch gap and inter-frame delay
// Optional: define WS2812_UNDERRUN_FILL_EN to substitute 0x00 for missing bytes instead of stalling.
module ws2812_frame_sched
  import ws2812_pkg::*;
#(
  parameter int RESET_CYCLES = DEF_RESET_CYCLES,
  parameter int DELAY_UNIT   = DEF_DELAY_UNIT,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             cfg_write,
  input  logic [15:0]      cfg_num_leds,
  input  logic [15:0]      cfg_data_delay,
  input  logic             pix_empty,
  input  logic [7:0]       pix_rd_data,
  output logic             pix_rd_en,
  output logic [23:0]      px_data,
  output logic             px_valid,
  input  logic             px_ready,
  output logic             latch,
  output logic             busy,
  output logic             frame_done,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] underrun_cnt
);
  state_t           r_state, w_next;
  logic [15:0]      r_sh_leds, r_sh_delay, r_leds, r_delay, r_led_cnt;
  logic [1:0]       r_idx;
  logic [23:0]      r_word;
  logic [CNT_W-1:0] r_frame_cnt;
  logic [15:0]      w_new_leds, w_new_delay, w_tmr_val;
  logic [7:0]       w_byte;
  logic             w_can_start, w_start, w_fill, w_take, w_last, w_tmr_load, w_tmr_pre, w_tmr_done;
  // a strobe in the same cycle as a frame start must be seen by that start
  assign w_new_leds = cfg_write ? cfg_num_leds : r_sh_leds;
  assign w_new_delay = cfg_write ? cfg_data_delay : r_sh_delay;
  assign w_can_start = enable && (w_new_leds != 16'd0);
  assign w_start = (w_next == FETCH) && (r_state inside {IDLE, LATCH, GAP});
  assign w_take = (r_state == CAPTURE) || w_fill;
  assign w_byte = w_fill ? 8'h00 : pix_rd_data;
  assign w_last = r_led_cnt == r_leds - 16'd1;
  assign pix_rd_en = (r_state == FETCH) && !pix_empty;
  assign px_valid = r_state == SEND;
  assign px_data = r_word;
  assign latch = r_state == LATCH;
  assign busy = r_state != IDLE;
  assign frame_done = (r_state == LATCH) && w_tmr_done;
  assign frame_cnt = r_frame_cnt;
`ifdef WS2812_UNDERRUN_FILL_EN
  logic [CNT_W-1:0] r_underrun;
  assign w_fill = (r_state == FETCH) && pix_empty;
  assign underrun_cnt = r_underrun;
  // one count per substituted byte
  always_ff @(posedge clk)
    if (reset) r_underrun <= '0;
    else if (w_fill) r_underrun <= r_underrun + CNT_W'(1);
`else
  assign w_fill = 1'b0;
  assign underrun_cnt = '0;
`endif
  // next state and timer loads: latch gap on the last handshake, delay gap when the latch ends
  always_comb begin
    w_next = r_state;
    w_tmr_load = 1'b0;
    w_tmr_pre = 1'b0;
    w_tmr_val = 16'(RESET_CYCLES);
    case (r_state)
      IDLE:    w_next = w_can_start ? FETCH : IDLE;
      FETCH:   w_next = w_fill ? (r_idx == SLOT_B ? SEND : FETCH) : (pix_empty ? FETCH : CAPTURE);
      CAPTURE: w_next = r_idx == SLOT_B ? SEND : FETCH;
      SEND: if (px_ready) begin
        w_next = w_last ? LATCH : FETCH;
        w_tmr_load = w_last;
      end
      LATCH: if (w_tmr_done) begin
        w_next = r_delay != 16'd0 ? GAP : (w_can_start ? FETCH : IDLE);
        w_tmr_load = r_delay != 16'd0;
        w_tmr_pre = 1'b1;
        w_tmr_val = r_delay;
      end
      GAP:     w_next = w_tmr_done ? (w_can_start ? FETCH : IDLE) : GAP;
      default: w_next = IDLE;
    endcase
  end
  // shadow config follows every strobe; active copy only changes at a frame start
  always_ff @(posedge clk)
    if (reset) begin
      r_sh_leds <= '0;
      r_sh_delay <= '0;
      r_leds <= '0;
      r_delay <= '0;
    end else begin
      r_sh_leds <= w_new_leds;
      r_sh_delay <= w_new_delay;
      if (w_start) begin
        r_leds <= w_new_leds;
        r_delay <= w_new_delay;
      end
    end
  // state, byte slot, LED index, packed word and completed-frame count
  always_ff @(posedge clk)
    if (reset) begin
      r_state <= IDLE;
      r_idx <= SLOT_G;
      r_led_cnt <= '0;
      r_word <= '0;
      r_frame_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_idx <= SLOT_G;
        r_led_cnt <= '0;
      end else begin
        if (w_take) r_idx <= r_idx == SLOT_B ? SLOT_G : r_idx + 2'd1;
        if (r_state == SEND && px_ready) r_led_cnt <= r_led_cnt + 16'd1;
      end
      if (w_take) r_word <= put_byte(r_word, r_idx, w_byte);
      if (frame_done) r_frame_cnt <= r_frame_cnt + CNT_W'(1);
    end
  ws2812_delay_timer #(.UNIT(DELAY_UNIT)) u_tmr (
    .clk(clk),
    .reset(reset),
    .i_load(w_tmr_load),
    .i_prescale(w_tmr_pre),
    .i_count(w_tmr_val),
    .o_done(w_tmr_done)
  );
endmodule

// File: tb/tb_ws2812_frame_sched.sv
// tb_ws2812_frame_sched: directed frame sequence with random pixel bytes, DELAY_UNIT overridden to 10
`timescale 1ns/1ps
module tb_ws2812_frame_sched;
  logic clk = 0, reset = 1, enable = 0, cfg_write = 0, px_ready = 1;
  logic [15:0] cfg_num_leds = 0, cfg_data_delay = 0;
  logic pix_empty, pix_rd_en, px_valid, latch, busy, frame_done;
  logic [7:0] pix_rd_data = 0;
  logic [23:0] px_data;
  logic [15:0] frame_cnt, underrun_cnt;
  int n_chk = 0, n_fail = 0;
  logic [7:0] mem [0:255];
  int wr_n = 0, rd_n = 0;
  logic [7:0] model_q [$];
  logic [23:0] got [$];
  int cyc = 0, latch_n = 0, done_n = 0, done_cyc = 0, rd_cyc = 0, bad_rd = 0;
  logic rd_seen = 1;

  ws2812_frame_sched #(.DELAY_UNIT(10)) dut (
    .clk(clk), .reset(reset), .enable(enable), .cfg_write(cfg_write),
    .cfg_num_leds(cfg_num_leds), .cfg_data_delay(cfg_data_delay),
    .pix_empty(pix_empty), .pix_rd_data(pix_rd_data), .pix_rd_en(pix_rd_en),
    .px_data(px_data), .px_valid(px_valid), .px_ready(px_ready),
    .latch(latch), .busy(busy), .frame_done(frame_done),
    .frame_cnt(frame_cnt), .underrun_cnt(underrun_cnt)
  );

  always #5 clk = ~clk;

  assign pix_empty = (wr_n == rd_n);

  // pixel FIFO: data appears the cycle after the pop
  always @(posedge clk)
    if (pix_rd_en) begin
      pix_rd_data <= mem[rd_n[7:0]];
      rd_n <= rd_n + 1;
    end

  // monitor: handshaked words, latch length, frame_done timing, illegal pops
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (px_valid && px_ready) got.push_back(px_data);
    if (latch) latch_n <= latch_n + 1;
    if (frame_done) begin
      done_n <= done_n + 1;
      done_cyc <= cyc;
      rd_seen <= 1'b0;
    end else if (pix_rd_en && !rd_seen) begin
      rd_cyc <= cyc;
      rd_seen <= 1'b1;
    end
    if (pix_rd_en && pix_empty) bad_rd <= bad_rd + 1;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_n[7:0]] = b;
    model_q.push_back(b);
    wr_n++;
  endtask

  // expected word: next three bytes in arrival order, 0x00 where the FIFO had nothing
  task automatic next_word(output logic [23:0] w);
    w = '0;
    for (int i = 0; i < 3; i++) w = {w[15:0], model_q.size() != 0 ? model_q.pop_front() : 8'h00};
  endtask

  task automatic wait_words(input int n, input int budget, input string tag);
    int k = 0;
    while (got.size() < n && k < budget) begin tick(); k++; end
    chk(tag, 32'(got.size() >= n), 1);
  endtask

  task automatic wait_done(input int n, input int budget, input string tag);
    int k = 0;
    while (done_n < n && k < budget) begin tick(); k++; end
    chk(tag, 32'(done_n >= n), 1);
    tick();
  endtask

  task automatic cfg(input logic [15:0] nl, input logic [15:0] dly);
    cfg_num_leds = nl;
    cfg_data_delay = dly;
    cfg_write = 1;
    tick();
    cfg_write = 0;
  endtask

  initial begin
    logic [23:0] w;
    int k, l0, busy_seen;
    tick(3);
    reset = 0;
    tick();
    chk("rst_valid", px_valid, 0);
    chk("rst_latch", latch, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_fcnt", frame_cnt, 0);
    chk("rst_urun", underrun_cnt, 0);
    chk("rst_pxdata", px_data, 0);
    for (int i = 1; i <= 6; i++) push(8'(i * 17));
    cfg(2, 0);
    tick(5);
    chk("idle_disabled_busy", busy, 0);
    chk("idle_disabled_rden", pix_rd_en, 0);
    enable = 1;
    wait_words(1, 50, "a_w0_timeout");
    cfg(5, 3);
    wait_words(2, 50, "a_w1_timeout");
    for (int i = 0; i < 13; i++) push(8'($urandom_range(0, 255)));
    wait_done(1, 15000, "a_done_timeout");
    next_word(w);
    chk("a_word0", got[0], w);
    next_word(w);
    chk("a_word1", got[1], w);
    chk("a_words_exact", got.size(), 2);
    chk("a_latch_len", latch_n, 14000);
    chk("a_latch_off", latch, 0);
    chk("a_done_once", done_n, 1);
    chk("a_fcnt", frame_cnt, 1);
    wait_words(6, 200, "b_w3_timeout");
    for (int i = 0; i < 4; i++) begin
      next_word(w);
      chk($sformatf("b_word%0d", i), got[2 + i], w);
    end
    tick(40);
`ifdef WS2812_UNDERRUN_FILL_EN
    next_word(w);
    chk("b_fill_words", got.size(), 7);
    chk("b_fill_word", got[6], w);
    chk("b_underrun", underrun_cnt, 2);
`else
    chk("b_stall_words", got.size(), 6);
    chk("b_stall_valid", px_valid, 0);
    chk("b_stall_rden", pix_rd_en, 0);
    chk("b_stall_busy", busy, 1);
    for (int i = 0; i < 2; i++) push(8'($urandom_range(0, 255)));
    next_word(w);
    wait_words(7, 50, "b_w4_timeout");
    chk("b_word4", got[6], w);
    chk("b_underrun_off", underrun_cnt, 0);
`endif
    for (int i = 0; i < 6; i++) push(8'($urandom_range(0, 255)));
    wait_done(2, 15000, "b_done_timeout");
    chk("b_words_exact", got.size(), 7);
    chk("b_fcnt", frame_cnt, 2);
    chk("b_latch_len", latch_n, 28000);
    k = 0;
    while (!rd_seen && k < 100) begin tick(); k++; end
    chk("gap_timeout", rd_seen, 1);
    chk("gap_len", rd_cyc - done_cyc, 31);
    k = 0;
    while (!px_valid && k < 50) begin tick(); k++; end
    chk("c_send_timeout", px_valid, 1);
    reset = 1;
    tick();
    chk("c_rst_valid", px_valid, 0);
    chk("c_rst_latch", latch, 0);
    chk("c_rst_busy", busy, 0);
    chk("c_rst_fcnt", frame_cnt, 0);
    chk("c_rst_urun", underrun_cnt, 0);
    chk("c_rst_done", frame_done, 0);
    reset = 0;
    next_word(w);
    chk("c_word0", got[7], w);
    cfg(0, 0);
    busy_seen = 0;
    for (int i = 0; i < 20; i++) begin tick(); busy_seen |= 32'(busy); end
    chk("nl0_busy", busy_seen, 0);
    chk("c_no_done", done_n, 2);
    l0 = latch_n;
    cfg(1, 0);
    enable = 0;
    wait_done(3, 15000, "d_done_timeout");
    next_word(w);
    chk("d_word", got[8], w);
    chk("d_latch_len", latch_n - l0, 14000);
    chk("d_fcnt", frame_cnt, 1);
    tick(3);
    chk("d_idle_busy", busy, 0);
    chk("d_words_exact", got.size(), 9);
    chk("rd_when_empty", bad_rd, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
